jk_counter_reg: RTL and testbench

- Parametrised WIDTH-bit register built from per-bit JK storage cells; successor to the single-bit JK flip-flop.
- Four modes:
  - direct per-bit JK control
  - modulo-MOD up count
  - modulo-MOD down count
  - parallel load
- Supplies q/qb vectors plus a terminal-count flag, so counters and dividers in later modules can be built on the same JK primitive.

---
 rtl/jk_counter_reg_pkg.sv | 21 ++
 rtl/jk_counter_reg_cell.sv | 33 +++
 rtl/jk_counter_reg.sv | 108 ++++++++++
 tb/tb_jk_counter_reg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jk_counter_reg_pkg.sv
// Shared definitions for the JK-cell based counter/register.
// Holds the mode encodings seen on jk_counter_reg.mode and the names of the
// JK truth-table rows as seen by a single jk_cell ({j,k}).
package jk_counter_reg_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,  // direct per-bit J/K control
    MODE_UP = 2'b01,  // modulo-MOD up count
    MODE_DN = 2'b10,  // modulo-MOD down count
    MODE_LD = 2'b11   // parallel load
  } mode_e;

  // Rows of the JK truth table, indexed by {j,k}.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

endpackage

// File: rtl/jk_counter_reg_cell.sv
// jk_cell: one-bit JK storage element.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset, loads rst_val
//   rst_val value taken by q while rst is high
//   j, k    JK controls: 00 hold, 01 clear, 10 set, 11 toggle
//   q       stored bit
module jk_cell
  import jk_counter_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      case ({j, k})
        JK_HOLD:   q <= q;
        JK_CLEAR:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_reg.sv
// jk_counter_reg: WIDTH-bit register built from jk_cell instances.
// Modes: direct per-bit JK, modulo-MOD up count, modulo-MOD down count,
// parallel load. All state lives in the cells; this level only decides
// which J/K vector each cell sees.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, q <= RST_VAL
//   en    clock enable (0 holds every bit, tc forced 0)
//   mode  00 JK, 01 up, 10 down, 11 load
//   j, k  per-bit JK controls (mode 00)
//   d     parallel load data (mode 11)
//   q     register state
//   qb    ~q
//   tc    terminal count, high in the cycle whose next edge wraps
module jk_counter_reg
  import jk_counter_reg_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MOD     = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] inc_mask;
  logic [WIDTH-1:0] dec_mask;
  logic             up_wrap;
  logic             dn_wrap;

  // Bits that flip on +1 / -1: XOR of the value with its successor or
  // predecessor. Driving these as J=K=mask toggles exactly those cells.
  assign inc_mask = q ^ (q + WIDTH'(1));
  assign dec_mask = q ^ (q - WIDTH'(1));

  // Out-of-range values take the wrap branch so the count recovers in one edge.
  assign up_wrap = (q >= TOP);
  assign dn_wrap = (q == '0) || (q > TOP);

  always_comb begin
    cell_j = '0;
    cell_k = '0;
    tc     = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: begin
          cell_j = j;
          cell_k = k;
        end
        MODE_UP: begin
          tc = up_wrap;
          if (up_wrap) begin
            cell_j = '0;
            cell_k = '1;
          end else begin
            cell_j = inc_mask;
            cell_k = inc_mask;
          end
        end
        MODE_DN: begin
          tc = dn_wrap;
          if (dn_wrap) begin
            cell_j = TOP;
            cell_k = ~TOP;
          end else begin
            cell_j = dec_mask;
            cell_k = dec_mask;
          end
        end
        MODE_LD: begin
          cell_j = d;
          cell_k = ~d;
        end
        default: begin
          cell_j = '0;
          cell_k = '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_Q[i]),
      .j       (cell_j[i]),
      .k       (cell_k[i]),
      .q       (q[i])
    );
  end

  assign qb = ~q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Testbench for jk_counter_reg: two instances (4-bit mod-10 reset 0 and
// 3-bit mod-8 reset 5), an arithmetic reference model per instance checked
// on every falling edge, and directed literal checks along the sequence.
module tb_jk_counter_reg;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MOD=10, RST_VAL=0
  logic       rst_a, en_a;
  logic [1:0] mode_a;
  logic [3:0] j_a, k_a, d_a, q_a, qb_a;
  logic       tc_a;

  // Instance B: WIDTH=3, MOD=8, RST_VAL=5
  logic       rst_b, en_b;
  logic [1:0] mode_b;
  logic [2:0] j_b, k_b, d_b, q_b, qb_b;
  logic       tc_b;

  int tests = 0;
  int fails = 0;

  jk_counter_reg #(.WIDTH(4), .MOD(10), .RST_VAL(0)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a),
    .j(j_a), .k(k_a), .d(d_a), .q(q_a), .qb(qb_a), .tc(tc_a)
  );

  jk_counter_reg #(.WIDTH(3), .MOD(8), .RST_VAL(5)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b),
    .j(j_b), .k(k_b), .d(d_b), .q(q_b), .qb(qb_b), .tc(tc_b)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-state from the mode rules, plain integer arithmetic.
  function automatic int model_next(input int qv, input int w, input int m,
                                    input logic e, input logic [1:0] md,
                                    input int jv, input int kv, input int dv);
    int msk;
    msk = (1 << w) - 1;
    if (!e) return qv;
    case (md)
      2'b00:   return (((qv | (jv & ~kv)) & ~(kv & ~jv)) ^ (jv & kv)) & msk;
      2'b01:   return (qv >= m - 1) ? 0 : qv + 1;
      2'b10:   return (qv == 0 || qv > m - 1) ? m - 1 : qv - 1;
      default: return dv & msk;
    endcase
  endfunction

  function automatic int model_tc(input int qv, input int m, input logic e,
                                  input logic [1:0] md);
    if (!e) return 0;
    if (md == 2'b01) return (qv >= m - 1) ? 1 : 0;
    if (md == 2'b10) return (qv == 0 || qv > m - 1) ? 1 : 0;
    return 0;
  endfunction

  int mq_a = 0;
  int mq_b = 5;

  always @(posedge clk or posedge rst_a)
    if (rst_a) mq_a <= 0;
    else       mq_a <= model_next(mq_a, 4, 10, en_a, mode_a, j_a, k_a, d_a);

  always @(posedge clk or posedge rst_b)
    if (rst_b) mq_b <= 5;
    else       mq_b <= model_next(mq_b, 3, 8, en_b, mode_b, j_b, k_b, d_b);

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("a_q_model",  int'(q_a),  mq_a);
    check("a_qb_model", int'(qb_a), (~mq_a) & 15);
    check("a_tc_model", int'(tc_a), model_tc(mq_a, 10, en_a, mode_a));
    check("b_q_model",  int'(q_b),  mq_b);
    check("b_qb_model", int'(qb_b), (~mq_b) & 7);
    check("b_tc_model", int'(tc_b), model_tc(mq_b, 8, en_b, mode_b));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_up [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int exp_dn [4]  = '{1, 0, 9, 8};

  initial begin
    rst_a = 1'b1; en_a = 1'b0; mode_a = 2'b00; j_a = '0; k_a = '0; d_a = '0;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 2'b00; j_b = '0; k_b = '0; d_b = '0;
    tick; tick;
    rst_a = 1'b0; rst_b = 1'b0;
    check("b_reset_val", int'(q_b), 5);
    check("a_reset_val", int'(q_a), 0);

    // Asynchronous reset with q=7, no clock edge involved
    en_a = 1'b1; mode_a = 2'b11; d_a = 4'd7; tick;
    check("a_load7", int'(q_a), 7);
    #2 rst_a = 1'b1;
    #1 check("a_async_rst_q", int'(q_a), 0);
    check("a_async_rst_qb", int'(qb_a), 15);
    tick; tick;
    check("a_rst_hold", int'(q_a), 0);
    rst_a = 1'b0;

    // JK direct
    mode_a = 2'b11; d_a = 4'b0101; tick;
    check("a_load5", int'(q_a), 5);
    mode_a = 2'b00; j_a = 4'b1010; k_a = 4'b0000; tick;
    check("a_jk_set", int'(q_a), 15);
    j_a = 4'b0011; k_a = 4'b0011; tick;
    check("a_jk_toggle", int'(q_a), 12);
    j_a = 4'b0000; k_a = 4'b1000; tick;
    check("a_jk_clear", int'(q_a), 4);

    // Up count from 0
    mode_a = 2'b11; d_a = 4'd0; tick;
    mode_a = 2'b01;
    for (int unsigned i = 0; i < 11; i++) begin
      tick;
      check("a_up_q", int'(q_a), exp_up[i]);
      check("a_up_tc", int'(tc_a), (exp_up[i] == 9) ? 1 : 0);
    end
    en_a = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick;
      check("a_hold_q", int'(q_a), 1);
      check("a_hold_tc", int'(tc_a), 0);
    end

    // Down count from 2
    en_a = 1'b1; mode_a = 2'b11; d_a = 4'd2; tick;
    mode_a = 2'b10;
    for (int unsigned i = 0; i < 4; i++) begin
      tick;
      check("a_dn_q", int'(q_a), exp_dn[i]);
      check("a_dn_tc", int'(tc_a), (exp_dn[i] == 0) ? 1 : 0);
    end

    // Out-of-range recovery
    mode_a = 2'b11; d_a = 4'd13; tick;
    check("a_load13", int'(q_a), 13);
    mode_a = 2'b01; #1;
    check("a_oor_up_tc", int'(tc_a), 1);
    tick;
    check("a_oor_up_q", int'(q_a), 0);
    mode_a = 2'b11; d_a = 4'd13; tick;
    mode_a = 2'b10; #1;
    check("a_oor_dn_tc", int'(tc_a), 1);
    tick;
    check("a_oor_dn_q", int'(q_a), 9);

    // Parametric wrap on instance B
    en_b = 1'b1; mode_b = 2'b01; #1;
    check("b_tc_at5", int'(tc_b), 0);
    tick; check("b_up6", int'(q_b), 6);
    tick; check("b_up7", int'(q_b), 7);
    check("b_tc_at7", int'(tc_b), 1);
    tick; check("b_wrap0", int'(q_b), 0);
    check("b_tc_at0", int'(tc_b), 0);
    tick; check("b_up1", int'(q_b), 1);
    #2 rst_b = 1'b1;
    #1 check("b_async_rst_q", int'(q_b), 5);
    check("b_async_rst_qb", int'(qb_b), 2);
    #1 rst_b = 1'b0;
    tick; check("b_after_rst", int'(q_b), 6);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
